// File: rtl/rf_bist_ctrl.sv
// Self-test initiator for the 2R/1W register file: writes a stride pattern to every
// address, reads it back on both ports and reports pass/fail with first-failure details.
module rf_bist_ctrl #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(32'h0000ffff),
  parameter logic [DATA_W-1:0] STRIDE = DATA_W'(32'h11110000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [6:0]        err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_port,
  output logic [DATA_W-1:0] fail_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr1,
  input  logic [DATA_W-1:0] rf_rdata1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata2
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] addr_prev;
  logic              mis1;
  logic              mis2;
  logic [6:0]        err_next;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return SEED + DATA_W'(a) * STRIDE;
  endfunction

  // r0 is hardwired to zero, so address 0 must read back 0 despite being written
  function automatic logic [DATA_W-1:0] expected_at(input logic [ADDR_W-1:0] a);
    return (a == '0) ? '0 : pattern(a);
  endfunction

  assign addr_next = addr + ADDR_W'(1);
  assign addr_prev = addr - ADDR_W'(1);
  assign mis1      = (state == READ) && (rf_rdata1 != expected_at(addr));
  assign mis2      = (state == READ) && (rf_rdata2 != expected_at(addr_prev));
  assign err_next  = err_cnt + 7'(mis1) + 7'(mis2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_port <= 1'b0;
      fail_data <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WRITE;
            addr      <= '0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_port <= 1'b0;
            fail_data <= '0;
            rf_we     <= 1'b1;
            rf_waddr  <= '0;
            rf_wdata  <= pattern('0);
          end else begin
            state <= IDLE;
          end
        end
        WRITE: begin
          if (addr == LAST) begin
            // port 2 trails port 1 by one address, wrapping to the top at the start
            state     <= READ;
            addr      <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            rf_raddr1 <= '0;
            rf_raddr2 <= LAST;
          end else begin
            addr     <= addr_next;
            rf_waddr <= addr_next;
            rf_wdata <= pattern(addr_next);
          end
        end
        READ: begin
          err_cnt <= err_next;
          if ((err_cnt == '0) && (mis1 || mis2)) begin
            fail_addr <= mis1 ? addr : addr_prev;
            fail_port <= !mis1;
            fail_data <= mis1 ? rf_rdata1 : rf_rdata2;
          end
          if (addr == LAST) begin
            state     <= DONE;
            addr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_next == '0);
            rf_raddr1 <= '0;
            rf_raddr2 <= '0;
          end else begin
            addr      <= addr_next;
            rf_raddr1 <= addr_next;
            rf_raddr2 <= addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_bist_ctrl.sv
// Bench for rf_bist_ctrl: a fault-injectable register file model plus a set-based
// prediction of the BIST verdict, driven by directed and randomized runs.
module tb_rf_bist_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [6:0]  err_cnt;
  logic [4:0]  fail_addr;
  logic        fail_port;
  logic [31:0] fail_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr1;
  logic [31:0] rf_rdata1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata2;

  int compared = 0;
  int mismatched = 0;

  // Fault knobs for the register file model
  bit          r0w = 1'b0;
  bit          stuck_en = 1'b0;
  logic [4:0]  stuck_addr = '0;
  logic [4:0]  stuck_bit = '0;
  bit          stuck_val = 1'b0;

  logic [31:0] mem [32];

  bit          exp_pass;
  logic [6:0]  exp_err;
  logic [4:0]  exp_faddr;
  bit          exp_fport;
  logic [31:0] exp_fdata;

  always #5 clk = ~clk;

  rf_bist_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_port(fail_port), .fail_data(fail_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
    .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2)
  );

  always @(posedge clk) begin
    if (rf_we) mem[rf_waddr] <= rf_wdata;
  end

  always_comb begin
    rf_rdata1 = (rf_raddr1 == 5'd0 && !r0w) ? 32'h0 : mem[rf_raddr1];
    if (stuck_en && rf_raddr1 == stuck_addr) rf_rdata1[stuck_bit] = stuck_val;
    rf_rdata2 = (rf_raddr2 == 5'd0 && !r0w) ? 32'h0 : mem[rf_raddr2];
    if (stuck_en && rf_raddr2 == stuck_addr) rf_rdata2[stuck_bit] = stuck_val;
  end

  function automatic logic [31:0] patAt(input logic [4:0] a);
    return 32'h0000ffff + {27'd0, a} * 32'h11110000;
  endfunction

  function automatic logic [31:0] expAt(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : patAt(a);
  endfunction

  // What a fully written regfile with the current faults returns at address a
  function automatic logic [31:0] obsAt(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0 && !r0w) ? 32'h0 : patAt(a);
    if (stuck_en && a == stuck_addr) v[stuck_bit] = stuck_val;
    return v;
  endfunction

  // Every faulty address is read once per port, so it costs two errors. The first
  // failure is at read step 0 (port 1 reads 0, port 2 reads 31) if either is faulty,
  // otherwise the lowest faulty address on port 1.
  task automatic computeExpected();
    int nfault;
    bit has0, has31;
    logic [4:0] minf;
    nfault = 0; has0 = 0; has31 = 0; minf = 5'd31;
    for (int i = 31; i >= 0; i--) begin
      if (obsAt(5'(i)) != expAt(5'(i))) begin
        nfault++;
        minf = 5'(i);
        if (i == 0) has0 = 1;
        if (i == 31) has31 = 1;
      end
    end
    exp_err  = 7'(2 * nfault);
    exp_pass = (nfault == 0);
    if (nfault == 0) begin
      exp_faddr = 5'd0; exp_fport = 1'b0;
    end else if (has0) begin
      exp_faddr = 5'd0; exp_fport = 1'b0;
    end else if (has31) begin
      exp_faddr = 5'd31; exp_fport = 1'b1;
    end else begin
      exp_faddr = minf; exp_fport = 1'b0;
    end
    exp_fdata = (nfault == 0) ? 32'h0 : obsAt(exp_faddr);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkResult(input string tag);
    checkOutput({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    checkOutput({tag, "_fail_addr"}, 32'(fail_addr), 32'(exp_faddr));
    checkOutput({tag, "_fail_port"}, 32'(fail_port), 32'(exp_fport));
    checkOutput({tag, "_fail_data"}, fail_data, exp_fdata);
  endtask

  // One full run from a start pulse; leaves the bench at the negedge of the done cycle
  // (hold keeps start high) or of the cycle after it.
  task automatic applyStimulus(input string tag, input bit hold, input bit poke);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_done_early"}, 32'(done), 32'd0);
      if (cyc <= 32) begin
        checkOutput({tag, "_we"}, 32'(rf_we), 32'd1);
        checkOutput({tag, "_waddr"}, 32'(rf_waddr), 32'(cyc - 1));
        checkOutput({tag, "_wdata"}, rf_wdata, patAt(5'(cyc - 1)));
        if (cyc == 2)  checkOutput({tag, "_wdata_r1"}, rf_wdata, 32'h1111ffff);
        if (cyc == 17) checkOutput({tag, "_wdata_r16"}, rf_wdata, 32'h1110ffff);
      end else begin
        checkOutput({tag, "_we_read"}, 32'(rf_we), 32'd0);
        checkOutput({tag, "_raddr1"}, 32'(rf_raddr1), 32'(cyc - 33));
        checkOutput({tag, "_raddr2"}, 32'(rf_raddr2), 32'((cyc - 34) & 31));
      end
      if (poke && cyc == 40) start = 1'b1;
      if (poke && cyc == 41) start = 1'b0;
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_we_done"}, 32'(rf_we), 32'd0);
    checkOutput({tag, "_raddr_done"}, 32'({rf_raddr1, rf_raddr2}), 32'd0);
    checkResult(tag);
    if (!hold) begin
      @(negedge clk);
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_pass_held"}, 32'(pass), 32'(exp_pass));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit saw_done;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    checkOutput("rst_err", 32'(err_cnt), 32'd0);
    checkOutput("rst_fail", 32'({fail_addr, fail_port}), 32'd0);
    checkOutput("rst_fdata", fail_data, 32'd0);
    checkOutput("rst_we", 32'(rf_we), 32'd0);
    checkOutput("rst_addrs", 32'({rf_waddr, rf_raddr1, rf_raddr2}), 32'd0);
    checkOutput("rst_wdata", rf_wdata, 32'd0);
    reset = 1'b0;

    // Good regfile, with a stray start pulse during READ
    computeExpected();
    applyStimulus("good", 1'b0, 1'b1);

    // r5 bit0 stuck at 0
    stuck_en = 1'b1; stuck_addr = 5'd5; stuck_bit = 5'd0; stuck_val = 1'b0;
    computeExpected();
    applyStimulus("stuck5", 1'b0, 1'b0);
    checkOutput("stuck5_fdata_const", fail_data, 32'h5555fffe);
    checkOutput("stuck5_err_const", 32'(err_cnt), 32'd2);
    stuck_en = 1'b0;

    // r0 writable
    r0w = 1'b1;
    computeExpected();
    applyStimulus("r0w", 1'b0, 1'b0);
    checkOutput("r0w_fdata_const", fail_data, 32'h0000ffff);
    r0w = 1'b0;

    // Reset during the 10th write cycle
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("mid_waddr", 32'(rf_waddr), 32'd9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_we", 32'(rf_we), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    checkOutput("mid_no_done", 32'(saw_done), 32'd0);
    computeExpected();
    applyStimulus("after_rst", 1'b0, 1'b0);

    // Faulty run with start held through DONE, then a good run with no IDLE gap
    r0w = 1'b1;
    computeExpected();
    applyStimulus("hold", 1'b1, 1'b0);
    r0w = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("hold_busy", 32'(busy), 32'd1);
    checkOutput("hold_err_clr", 32'(err_cnt), 32'd0);
    checkOutput("hold_pass_clr", 32'(pass), 32'd0);
    checkOutput("hold_we", 32'(rf_we), 32'd1);
    checkOutput("hold_waddr", 32'(rf_waddr), 32'd0);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    checkOutput("hold_done_seen", 32'(done), 32'd1);
    computeExpected();
    checkResult("b2b");
    @(negedge clk);

    // Randomized fault scenarios
    for (int r = 0; r < 6; r++) begin
      r0w        = 1'($urandom_range(0, 1));
      stuck_en   = 1'($urandom_range(0, 1));
      stuck_addr = 5'($urandom_range(0, 31));
      stuck_bit  = 5'($urandom_range(0, 31));
      stuck_val  = 1'($urandom_range(0, 1));
      $display("[TB] random run %0d: r0w=%0d stuck=%0d addr=%0d bit=%0d val=%0d",
               r, r0w, stuck_en, stuck_addr, stuck_bit, stuck_val);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      computeExpected();
      applyStimulus("rand", 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
